// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch front end of mips_cpu:
//   fetch_state_t    - fetch FSM state encoding
//   NOP_INSTR        - instruction presented to the core out of reset
//   DEFAULT_RESET_PC - default PC loaded on reset
//   is_word_aligned  - helper that tests the two low address bits
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory req/ack bus between fetch_unit and the instruction memory.
//   imem_req   - read request, held stable until acknowledged
//   imem_addr  - word address of the requested instruction
//   imem_ack   - read data valid
//   imem_rdata - read data
// Modports: master (fetch side), slave (memory side).
// ---------------------------------------------------------------------------
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// 32-bit program-counter register with load enable.
//   clk   - clock
//   rst_n - asynchronous active-low reset, loads RESET_VAL
//   load  - when high, q takes d on the rising edge
//   d     - next value
//   q     - current value
// ---------------------------------------------------------------------------
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of the single-cycle mips_cpu. Owns the PC,
// fetches one instruction per trip through REQ/EXEC and emits a one-cycle
// commit pulse that gates the core's write enables.
//   clk       - clock
//   rst_n     - asynchronous active-low reset
//   pc        - current PC to the core
//   pc_new    - next PC computed by the core
//   instr     - latched instruction to the core
//   commit    - high during the single execute cycle of an instruction
//   stall     - external hold, blocks commit while in EXEC
//   imem      - instruction memory req/ack bus (master side)
//   fetch_err - sticky error: fetch timeout or misaligned pc_new
//   retired   - number of committed instructions (wraps)
// ---------------------------------------------------------------------------
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] pc_new,
  output logic [31:0] instr,
  output logic        commit,
  input  logic        stall,
  fetch_unit_if.master imem,
  output logic        fetch_err,
  output logic [31:0] retired
);

  // Last REQ cycle index in which an ack is still accepted; no ack here times out.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [7:0]   wait_cnt;
  logic [31:0]  retired_cnt;
  logic         pc_aligned;
  logic         pc_load;

  assign pc_aligned = is_word_aligned(pc_new);
  // A misaligned target still commits the faulting instruction, but the PC holds.
  assign pc_load    = commit && pc_aligned;
  assign retired    = retired_cnt;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (pc_new),
    .q     (pc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.imem_ack) begin
          state_d = EXEC;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = HALT;
        end
      end
      EXEC: begin
        if (!stall) begin
          state_d = pc_aligned ? REQ : HALT;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: registered state only, plus the stall -> commit path
  always_comb begin
    imem.imem_req  = (state_q == REQ);
    imem.imem_addr = pc;
    commit         = (state_q == EXEC) && !stall;
  end

  // Instruction latch, wait counter, error flag and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= NOP_INSTR;
      wait_cnt    <= 8'd0;
      fetch_err   <= 1'b0;
      retired_cnt <= 32'd0;
    end else begin
      case (state_q)
        REQ: begin
          if (imem.imem_ack) begin
            instr    <= imem.imem_rdata;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              fetch_err <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (commit) begin
            retired_cnt <= retired_cnt + 32'd1;
            if (!pc_aligned) begin
              fetch_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Inputs change 1 time unit after a rising
// edge; outputs are sampled a further unit later, away from the clock edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_new;
  logic [31:0] instr;
  logic        commit;
  logic        stall;
  logic        fetch_err;
  logic [31:0] retired;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .pc_new    (pc_new),
    .instr     (instr),
    .commit    (commit),
    .stall     (stall),
    .imem      (imem.master),
    .fetch_err (fetch_err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},      pc,                     32'h0);
    check({tag, "_instr"},   instr,                  NOP_INSTR);
    check({tag, "_commit"},  32'(commit),            32'd0);
    check({tag, "_req"},     32'(imem.imem_req),     32'd0);
    check({tag, "_addr"},    imem.imem_addr,         32'h0);
    check({tag, "_err"},     32'(fetch_err),         32'd0);
    check({tag, "_retired"}, retired,                32'd0);
  endtask

  initial begin
    stall           = 1'b0;
    pc_new          = 32'h0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");

    // Zero-wait fetch of addi at 0x0: IDLE, REQ, EXEC(commit), then pc = 4
    rst_n           = 1'b1;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h2008_0005;
    pc_new          = 32'h0000_0004;
    #1;
    check("t1_idle_req", 32'(imem.imem_req), 32'd0);
    step();
    #1;
    check("t1_req",        32'(imem.imem_req), 32'd1);
    check("t1_addr",       imem.imem_addr,     32'h0);
    check("t1_req_commit", 32'(commit),        32'd0);
    step();
    imem.imem_ack = 1'b0;
    #1;
    check("t1_commit",   32'(commit),        32'd1);
    check("t1_instr",    instr,              32'h2008_0005);
    check("t1_exec_req", 32'(imem.imem_req), 32'd0);
    step();
    #1;
    check("t1_pc",      pc,                 32'h4);
    check("t1_retired", retired,            32'd1);
    check("t1_commit0", 32'(commit),        32'd0);
    check("t1_addr4",   imem.imem_addr,     32'h4);

    // Ack delayed 3 cycles: 4 REQ cycles with stable address, then one EXEC
    imem.imem_rdata = 32'h8C09_0000;
    pc_new          = 32'h0000_0008;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem.imem_ack = 1'b1;
      #1;
      check("t2_req",    32'(imem.imem_req), 32'd1);
      check("t2_addr",   imem.imem_addr,     32'h4);
      check("t2_commit", 32'(commit),        32'd0);
      step();
    end
    imem.imem_ack = 1'b0;
    #1;
    check("t2_commit_exec", 32'(commit), 32'd1);
    check("t2_instr",       instr,       32'h8C09_0000);
    step();
    #1;
    check("t2_pc",      pc,          32'h8);
    check("t2_retired", retired,     32'd2);
    check("t2_commit0", 32'(commit), 32'd0);

    // Stall held for 4 EXEC cycles; ack/rdata activity in EXEC is ignored
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h0109_5020;
    stall           = 1'b1;
    #1;
    check("t3_req", 32'(imem.imem_req), 32'd1);
    step();
    imem.imem_rdata = 32'hDEAD_BEEF;
    pc_new          = 32'h0000_000C;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_commit",  32'(commit), 32'd0);
      check("t3_pc",      pc,          32'h8);
      check("t3_retired", retired,     32'd2);
      check("t3_instr",   instr,       32'h0109_5020);
      step();
    end
    stall         = 1'b0;
    imem.imem_ack = 1'b0;
    #1;
    check("t3_release_commit", 32'(commit), 32'd1);
    step();
    #1;
    check("t3_pc_adv",  pc,      32'hC);
    check("t3_retired", retired, 32'd3);
    check("t3_instr",   instr,   32'h0109_5020);

    // Ack in the 15th REQ cycle (MAX_WAIT) is still accepted
    pc_new          = 32'h0000_0010;
    imem.imem_rdata = 32'h1234_5678;
    for (int i = 1; i <= 14; i++) begin
      #1;
      check("t4_req", 32'(imem.imem_req), 32'd1);
      step();
    end
    imem.imem_ack = 1'b1;
    #1;
    check("t4_req15", 32'(imem.imem_req), 32'd1);
    check("t4_err",   32'(fetch_err),     32'd0);
    step();
    imem.imem_ack = 1'b0;
    #1;
    check("t4_commit",   32'(commit),    32'd1);
    check("t4_instr",    instr,          32'h1234_5678);
    check("t4_err_exec", 32'(fetch_err), 32'd0);
    step();
    #1;
    check("t4_pc",      pc,      32'h10);
    check("t4_retired", retired, 32'd4);

    // No ack for 15 REQ cycles: timeout, HALT, later acks ignored
    for (int i = 1; i <= 15; i++) begin
      #1;
      check("t5_req",     32'(imem.imem_req), 32'd1);
      check("t5_err_pre", 32'(fetch_err),     32'd0);
      step();
    end
    #1;
    check("t5_err",    32'(fetch_err),     32'd1);
    check("t5_req0",   32'(imem.imem_req), 32'd0);
    check("t5_commit", 32'(commit),        32'd0);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      step();
      #1;
      check("t5_halt_req",     32'(imem.imem_req), 32'd0);
      check("t5_halt_err",     32'(fetch_err),     32'd1);
      check("t5_halt_instr",   instr,              32'h1234_5678);
      check("t5_halt_retired", retired,            32'd4);
      check("t5_halt_pc",      pc,                 32'h10);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("t5_rst");

    // Misaligned pc_new: commit once, pc held, sticky error, HALT
    step();
    rst_n           = 1'b1;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h2008_0005;
    pc_new          = 32'h0000_0042;
    stall           = 1'b0;
    step();
    step();
    #1;
    check("t6_commit", 32'(commit),    32'd1);
    check("t6_err0",   32'(fetch_err), 32'd0);
    step();
    #1;
    check("t6_pc",      pc,                 32'h0);
    check("t6_err",     32'(fetch_err),     32'd1);
    check("t6_retired", retired,            32'd1);
    check("t6_commit0", 32'(commit),        32'd0);
    check("t6_req0",    32'(imem.imem_req), 32'd0);
    step();
    #1;
    check("t6_halt_req",    32'(imem.imem_req), 32'd0);
    check("t6_halt_commit", 32'(commit),        32'd0);

    // Retired counter wrap, then asynchronous reset during EXEC
    rst_n = 1'b0;
    #1;
    step();
    force dut.retired_cnt = 32'hFFFF_FFFF;
    rst_n         = 1'b1;
    pc_new        = 32'h0000_0004;
    imem.imem_ack = 1'b1;
    step();
    #1;
    check("t7_preload", retired, 32'hFFFF_FFFF);
    release dut.retired_cnt;
    step();
    imem.imem_ack = 1'b0;
    #1;
    check("t7_commit", 32'(commit), 32'd1);
    step();
    #1;
    check("t7_wrap", retired, 32'd0);
    check("t7_pc",   pc,      32'h4);
    imem.imem_ack = 1'b1;
    step();
    #1;
    check("t7_exec_commit", 32'(commit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7_async_commit", 32'(commit),        32'd0);
    check("t7_async_req",    32'(imem.imem_req), 32'd0);
    check("t7_async_pc",     pc,                 32'h0);
    check("t7_async_ret",    retired,            32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of `mips_cpu`. It owns the architectural PC register and drives `pc` into the core. It fetches each instruction from a variable-latency instruction memory over a req/ack handshake and presents it to the core's `instruction_memory_rd`. It takes the core's `pc_new` and emits a one-cycle `commit` pulse, which the top level ANDs into `register_we3` and `data_memory_we`, so that the single-cycle core updates state exactly once per instruction.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `MAX_WAIT`, default 15: maximum cycles spent in REQ without an ack before an error is raised; range 1–255.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `pc`  out  32  Current PC; connects to `mips_cpu.pc`.
- `pc_new`  in  32  Next PC from `mips_cpu`.
- `instr`  out  32  Latched instruction; connects to `mips_cpu.instruction_memory_rd`.
- `commit`  out  1  High for the single execute cycle of an instruction; gates core write enables.
- `stall`  in  1  External hold; blocks commit.
- `imem_req`  out  1  Instruction memory request.
- `imem_addr`  out  32  Request address; equals `pc`.
- `imem_ack`  in  1  Read data valid.
- `imem_rdata`  in  32  Read data.
- `fetch_err`  out  1  Sticky error flag; set on timeout or misaligned `pc_new`.
- `retired`  out  32  Count of committed instructions.

## Operation
- FSM states: IDLE, REQ, EXEC, HALT.
- IDLE: entered on reset, lasts one cycle, then goes to REQ.
- REQ:
  - `imem_req` = 1 and `imem_addr` = `pc`, both held stable.
  - When `imem_ack` is sampled high: `instr` <= `imem_rdata`, wait counter clears, next state EXEC.
  - Otherwise the wait counter increments. When it reaches `MAX_WAIT` with no ack: `fetch_err` <= 1, next state HALT.
- EXEC:
  - `commit` = !`stall`; `imem_req` = 0.
  - If `stall` = 1: stay in EXEC; `pc`, `instr` and `retired` are held.
  - If `stall` = 0 and `pc_new[1:0]` == 0: `pc` <= `pc_new`, `retired` <= `retired` + 1 (wraps modulo 2^32), next state REQ.
  - If `stall` = 0 and `pc_new[1:0]` != 0: `commit` is still high this cycle, because the faulting instruction itself commits. `retired` increments, `pc` is held, `fetch_err` <= 1, next state HALT.
- HALT: `imem_req` = 0 and `commit` = 0. Only reset exits HALT.
- `imem_ack` is ignored in every state except REQ.
- `stall` during REQ does not abort or alter the request; it only affects EXEC.
- `pc_new` arithmetic is done in the core. This block never adds to the PC itself.

## Timing
- Reset values: `pc` = `RESET_PC`, `instr` = 32'h0000_0000 (NOP), `commit` = 0, `imem_req` = 0, `imem_addr` = `RESET_PC`, `fetch_err` = 0, `retired` = 0, state IDLE, wait counter 0.
- Asserting `rst_n` low mid-transaction drops `imem_req` and `commit` immediately (asynchronously).
- Zero-wait memory (ack in the first REQ cycle) gives a minimum of 2 cycles per instruction: REQ then EXEC. With N wait cycles the cost is N + 2 cycles.
- Throughput after reset: the first `commit` occurs no earlier than cycle 3 (IDLE, REQ, EXEC).
- `commit`, `imem_req` and `imem_addr` are decoded from registered state only. No input-to-output combinational path exists except `stall` -> `commit`.
- Ack arriving exactly on the `MAX_WAIT` cycle is accepted; the timeout fires only when the counter reaches `MAX_WAIT` without an ack.

## Structure
- Shared package `mips_pkg` holds:
  - state encoding constants (IDLE = 2'd0, REQ = 2'd1, EXEC = 2'd2, HALT = 2'd3);
  - `NOP_INSTR` = 32'h0000_0000;
  - default `RESET_PC`.
- One sub-module, `pc_reg`: a 32-bit register with async active-low reset to a parameterised value and a load enable. It replaces the plain PC flop used around the core today.
- The FSM, wait counter and retired counter live in `fetch_unit`.

## Test plan
- Zero-wait memory returning 32'h2008_0005 (`addi $t0,$0,5`) at 0x0; core returns `pc_new` = 0x4 -> `commit` pulses in cycle 3, `pc` = 0x4 in cycle 4, `retired` = 1.
- Ack delayed 3 cycles -> `imem_req` high for 4 cycles with `imem_addr` stable; exactly one `commit`; 5 cycles per instruction.
- `stall` held high for 4 cycles in EXEC -> `commit` = 0 throughout and `pc`/`retired` unchanged; on release, one `commit` and `pc` advances.
- No ack for `MAX_WAIT` = 15 cycles -> `fetch_err` = 1 and `imem_req` = 0 thereafter; later ack pulses are ignored; `rst_n` low clears everything to reset values.
- `pc_new` = 0x0000_0042 (misaligned) -> `commit` pulses once, `pc` is held, `fetch_err` = 1, state HALT.
- `retired` preloaded to 32'hFFFF_FFFF via force, then one commit -> `retired` = 0.
